// File: rtl/nonce_tx_scheduler.sv
// Round-robin scheduler that serialises per-slave 32-bit nonces onto one byte transmitter.
// Define HUB_SLAVE_ID_EN to prefix each frame with a {5'b0, slave index} byte.
module nonce_tx_scheduler #(
   parameter int NUM_SLAVES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [32*NUM_SLAVES-1:0] nonce_in,
   input  logic [NUM_SLAVES-1:0]    new_nonce,
   input  logic                     TxD_busy,
   output logic                     TxD_start,
   output logic [7:0]               TxD_data,
   input  logic                     overflow_clr,
   output logic [NUM_SLAVES-1:0]    overflow,
   output logic                     busy
);

   localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
`ifdef HUB_SLAVE_ID_EN
   localparam logic [2:0] FIRST_REM = 3'd4;
`else
   localparam logic [2:0] FIRST_REM = 3'd3;
`endif

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      WAIT_IDLE
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   pend_q, pend_d;
   logic [NUM_SLAVES-1:0]   ovf_q, ovf_d;
   logic [31:0]             nbuf_q [NUM_SLAVES];
   logic [31:0]             nbuf_d [NUM_SLAVES];
   logic [IW-1:0]           last_q, last_d;
   logic [31:0]             shift_q, shift_d;
   logic [7:0]              data_q, data_d;
   logic [2:0]              rem_q, rem_d;
   logic [1:0]              tmo_q, tmo_d;

   logic                    gnt_vld;
   logic [IW-1:0]           gnt_idx;
   logic [IW-1:0]           cand;
   logic                    take;
   logic [NUM_SLAVES-1:0]   gnt_oh;

   // Scan downward so the nearest pending slave after last_q wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = last_q;
      cand    = '0;
      for (int k = NUM_SLAVES; k >= 1; k--) begin
         cand = IW'((int'(last_q) + k) % NUM_SLAVES);
         if (pend_q[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign take = (state_q == IDLE) && gnt_vld;

   always_comb begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
         gnt_oh[i] = take && (gnt_idx == IW'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      nbuf_d    = nbuf_q;
      last_d    = last_q;
      shift_d   = shift_q;
      data_d    = data_q;
      rem_d     = rem_q;
      tmo_d     = tmo_q;
      TxD_start = 1'b0;

      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (overflow_clr) begin
            ovf_d[i] = 1'b0;
         end
         if (new_nonce[i]) begin
            nbuf_d[i] = nonce_in[32*i +: 32];
            pend_d[i] = 1'b1;
            if (pend_q[i] && !gnt_oh[i]) begin
               ovf_d[i] = 1'b1;
            end
         end else if (gnt_oh[i]) begin
            pend_d[i] = 1'b0;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               last_d  = gnt_idx;
               rem_d   = FIRST_REM;
`ifdef HUB_SLAVE_ID_EN
               data_d  = {5'b0, 3'(gnt_idx)};
               shift_d = nbuf_q[gnt_idx];
`else
               data_d  = nbuf_q[gnt_idx][31:24];
               shift_d = {nbuf_q[gnt_idx][23:0], 8'h00};
`endif
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = START;
         end
         START: begin
            if (!TxD_busy) begin
               TxD_start = 1'b1;
               tmo_d     = 2'd0;
               state_d   = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // A transmitter that never reports busy is assumed to have taken the byte.
            if (TxD_busy || tmo_q == 2'd3) begin
               state_d = WAIT_IDLE;
            end else begin
               tmo_d = tmo_q + 2'd1;
            end
         end
         WAIT_IDLE: begin
            if (!TxD_busy) begin
               if (rem_q != 3'd0) begin
                  data_d  = shift_q[31:24];
                  shift_d = {shift_q[23:0], 8'h00};
                  rem_d   = rem_q - 3'd1;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ovf_q   <= '0;
         last_q  <= IW'(NUM_SLAVES - 1);
         shift_q <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         tmo_q   <= '0;
         for (int i = 0; i < NUM_SLAVES; i++) begin
            nbuf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
         for (int i = 0; i < NUM_SLAVES; i++) begin
            nbuf_q[i] <= nbuf_d[i];
         end
      end
   end

   assign TxD_data = data_q;
   assign overflow = ovf_q;
   assign busy     = (state_q != IDLE) || (|pend_q);

endmodule
